// File: rtl/instr_fetch_unit_pkg.sv
// Purpose: shared constants, state encoding and entry type for the instruction fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_fetch_unit_pkg;

  localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] IFU_PC_INC   = 32'd4;

  // RV32 base-format field positions within the instruction word.
  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int RD_LSB     = 7;
  localparam int RD_MSB     = 11;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int RS1_LSB    = 15;
  localparam int RS1_MSB    = 19;
  localparam int RS2_LSB    = 20;
  localparam int RS2_MSB    = 24;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_MSB = 31;

  typedef enum logic [1:0] {
    IFU_IDLE  = 2'd0,
    IFU_FETCH = 2'd1,
    IFU_FAULT = 2'd2
  } ifu_state_t;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } ifu_entry_t;

  function automatic logic word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/ifu_skid_buf.sv
// Purpose: 1-entry holding register (word + PC) for a fetch response that lands while decode stalls.
// Latency: written data is readable the cycle after the write.
// Backpressure: full flag tells the owner to stop issuing reads; clr has priority over wr, wr over rd.
// Ports: clk/rst_n (async active-low), wr_en + wr_dat load the entry, rd_en pops it,
//        clr empties it, rd_dat is the held entry, full flags a valid entry.
module ifu_skid_buf
  import instr_fetch_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic       clr,
  input  ifu_entry_t wr_dat,
  output ifu_entry_t rd_dat,
  output logic       full
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= 1'b0;
      rd_dat <= '0;
    end else if (clr) begin
      full <= 1'b0;
    end else if (wr_en) begin
      full   <= 1'b1;
      rd_dat <= wr_dat;
    end else if (rd_en) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Purpose: owns the PC, reads a 1-cycle-latency instruction memory and presents decoded fields to decode.
// Latency: read issued in cycle N is presented in cycle N+2; 1 instruction/cycle when not stalled.
// Backpressure: ip_stall holds the output; one in-flight word parks in a skid entry; redirect beats stall.
// Ports: ip_clk/ip_rst_n; ip_stall from decode; ip_redirect_en/_pc from execute;
//        op_imem_rd_en/op_imem_addr/ip_imem_rd_data to memory; op_instr_valid/op_instr/op_pc and
//        the field slices to decode; op_misaligned_fault sticky until reset.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter logic [31:0] PC_INC   = IFU_PC_INC
) (
  input  logic        ip_clk,
  input  logic        ip_rst_n,
  input  logic        ip_stall,
  input  logic        ip_redirect_en,
  input  logic [31:0] ip_redirect_pc,
  output logic        op_imem_rd_en,
  output logic [31:0] op_imem_addr,
  input  logic [31:0] ip_imem_rd_data,
  output logic        op_instr_valid,
  output logic [31:0] op_instr,
  output logic [31:0] op_pc,
  output logic [6:0]  op_opcode,
  output logic [2:0]  op_funct_3,
  output logic [6:0]  op_funct_7,
  output logic [4:0]  op_rd,
  output logic [4:0]  op_rs1,
  output logic [4:0]  op_rs2,
  output logic        op_misaligned_fault
);

  ifu_state_t  state, state_nxt;
  logic [31:0] fetch_pc, fetch_pc_nxt;
  logic        inflight;     // a read issued last cycle returns its data this cycle
  logic [31:0] inflight_pc;
  logic        resp_vld;
  logic        rd_en;
  logic        skid_full, skid_wr, skid_rd, skid_clr;
  ifu_entry_t  skid_dat, resp_dat, out_dat;
  logic        out_ld, valid_nxt;

  assign resp_dat = {inflight_pc, ip_imem_rd_data};

  ifu_skid_buf u_skid (
    .clk    (ip_clk),
    .rst_n  (ip_rst_n),
    .wr_en  (skid_wr),
    .rd_en  (skid_rd),
    .clr    (skid_clr),
    .wr_dat (resp_dat),
    .rd_dat (skid_dat),
    .full   (skid_full)
  );

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    rd_en        = 1'b0;
    skid_wr      = 1'b0;
    skid_rd      = 1'b0;
    skid_clr     = 1'b0;
    out_ld       = 1'b0;
    out_dat      = resp_dat;
    valid_nxt    = op_instr_valid;
    // Data returning in a redirect cycle belongs to the wrong path and is dropped.
    resp_vld     = inflight && !ip_redirect_en;
    unique case (state)
      IFU_IDLE: begin
        state_nxt = IFU_FETCH;
        valid_nxt = 1'b0;
      end
      IFU_FETCH: begin
        if (ip_redirect_en) begin
          skid_clr     = 1'b1;
          valid_nxt    = 1'b0;
          fetch_pc_nxt = ip_redirect_pc;
          if (!word_aligned(ip_redirect_pc)) state_nxt = IFU_FAULT;
        end else if (ip_stall) begin
          // Output holds; at most one word can be in flight when the stall starts.
          skid_wr = resp_vld;
        end else begin
          // A parked word is older than anything in flight, so it goes out first.
          skid_rd   = skid_full;
          out_dat   = skid_full ? skid_dat : resp_dat;
          out_ld    = skid_full || resp_vld;
          valid_nxt = out_ld;
          // The skid entry drains this cycle, so it no longer holds off the next read.
          rd_en        = 1'b1;
          fetch_pc_nxt = fetch_pc + PC_INC;
        end
      end
      IFU_FAULT: valid_nxt = 1'b0;
      default: state_nxt = IFU_IDLE;
    endcase
  end

  always_ff @(posedge ip_clk or negedge ip_rst_n) begin
    if (!ip_rst_n) begin
      state          <= IFU_IDLE;
      fetch_pc       <= RESET_PC;
      inflight       <= 1'b0;
      inflight_pc    <= '0;
      op_instr_valid <= 1'b0;
      op_instr       <= '0;
      op_pc          <= '0;
    end else begin
      state          <= state_nxt;
      fetch_pc       <= fetch_pc_nxt;
      inflight       <= rd_en;
      if (rd_en) inflight_pc <= fetch_pc;
      op_instr_valid <= valid_nxt;
      if (out_ld) begin
        op_instr <= out_dat.word;
        op_pc    <= out_dat.pc;
      end
    end
  end

  assign op_imem_rd_en       = rd_en;
  assign op_imem_addr        = fetch_pc;
  assign op_misaligned_fault = (state == IFU_FAULT);

  assign op_opcode  = op_instr[OPCODE_MSB:OPCODE_LSB];
  assign op_rd      = op_instr[RD_MSB:RD_LSB];
  assign op_funct_3 = op_instr[FUNCT3_MSB:FUNCT3_LSB];
  assign op_rs1     = op_instr[RS1_MSB:RS1_LSB];
  assign op_rs2     = op_instr[RS2_MSB:RS2_LSB];
  assign op_funct_7 = op_instr[FUNCT7_MSB:FUNCT7_LSB];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Purpose: directed + randomized bench for instr_fetch_unit with an instruction-stream reference model.
// Latency: n/a.
// Backpressure: drives ip_stall / ip_redirect_en directly.
module tb_instr_fetch_unit;

  logic        ip_clk_tb = 1'b0;
  logic        ip_rst_n = 1'b0;
  logic        ip_stall = 1'b0;
  logic        ip_redirect_en = 1'b0;
  logic [31:0] ip_redirect_pc = '0;
  logic [31:0] ip_imem_rd_data = '0;
  logic        op_imem_rd_en;
  logic [31:0] op_imem_addr;
  logic        op_instr_valid;
  logic [31:0] op_instr;
  logic [31:0] op_pc;
  logic [6:0]  op_opcode;
  logic [2:0]  op_funct_3;
  logic [6:0]  op_funct_7;
  logic [4:0]  op_rd;
  logic [4:0]  op_rs1;
  logic [4:0]  op_rs2;
  logic        op_misaligned_fault;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_pc;
  logic [31:0] rpc;
  logic        st, re, prev_re;
  int          consumed;

  always #5 ip_clk_tb = ~ip_clk_tb;

  instr_fetch_unit dut (
    .ip_clk              (ip_clk_tb),
    .ip_rst_n            (ip_rst_n),
    .ip_stall            (ip_stall),
    .ip_redirect_en      (ip_redirect_en),
    .ip_redirect_pc      (ip_redirect_pc),
    .op_imem_rd_en       (op_imem_rd_en),
    .op_imem_addr        (op_imem_addr),
    .ip_imem_rd_data     (ip_imem_rd_data),
    .op_instr_valid      (op_instr_valid),
    .op_instr            (op_instr),
    .op_pc               (op_pc),
    .op_opcode           (op_opcode),
    .op_funct_3          (op_funct_3),
    .op_funct_7          (op_funct_7),
    .op_rd               (op_rd),
    .op_rs1              (op_rs1),
    .op_rs2              (op_rs2),
    .op_misaligned_fault (op_misaligned_fault)
  );

  // Program image: two fixed words at the bottom, a scrambled address everywhere else.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0037;
    if (a == 32'h4) return 32'h0000_0017;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Synchronous memory: data for a read strobed at an edge is on the bus for the following cycle.
  always @(posedge ip_clk_tb) begin
    if (op_imem_rd_en) ip_imem_rd_data <= mem_word(op_imem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, then move to mid-cycle for sampling.
  task automatic go(input logic s, input logic r, input logic [31:0] p);
    @(posedge ip_clk_tb);
    #1;
    ip_stall       = s;
    ip_redirect_en = r;
    ip_redirect_pc = p;
    #4;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc);
    logic [31:0] w;
    w = mem_word(pc);
    chk({tag, ".valid"}, 32'(op_instr_valid), 32'd1);
    chk({tag, ".pc"}, op_pc, pc);
    chk({tag, ".instr"}, op_instr, w);
    chk({tag, ".opcode"}, 32'(op_opcode), 32'(w[6:0]));
    chk({tag, ".rd"}, 32'(op_rd), 32'(w[11:7]));
    chk({tag, ".funct3"}, 32'(op_funct_3), 32'(w[14:12]));
    chk({tag, ".rs1"}, 32'(op_rs1), 32'(w[19:15]));
    chk({tag, ".rs2"}, 32'(op_rs2), 32'(w[24:20]));
    chk({tag, ".funct7"}, 32'(op_funct_7), 32'(w[31:25]));
  endtask

  task automatic chk_rd(input string tag, input logic en, input logic [31:0] addr);
    chk({tag, ".rd_en"}, 32'(op_imem_rd_en), 32'(en));
    if (en) chk({tag, ".addr"}, op_imem_addr, addr);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge ip_clk_tb);
    #5;
    chk("rst.valid", 32'(op_instr_valid), 32'd0);
    chk("rst.rd_en", 32'(op_imem_rd_en), 32'd0);
    chk("rst.addr", op_imem_addr, 32'h0);
    chk("rst.instr", op_instr, 32'h0);
    chk("rst.pc", op_pc, 32'h0);
    chk("rst.fault", 32'(op_misaligned_fault), 32'd0);
    @(posedge ip_clk_tb);
    #1 ip_rst_n = 1'b1;
    #4 chk("idle.rd_en", 32'(op_imem_rd_en), 32'd0);

    // Sequential fetch from reset.
    go(0, 0, 0); chk_rd("c0", 1, 32'h0); chk("c0.valid", 32'(op_instr_valid), 0);
    go(0, 0, 0); chk_rd("c1", 1, 32'h4); chk("c1.valid", 32'(op_instr_valid), 0);
    go(0, 0, 0); chk_rd("c2", 1, 32'h8); chk_out("c2", 32'h0);
    chk("c2.lui", 32'(op_opcode), 32'h37);
    // Stall 3 cycles while the 0x8 word is in flight.
    go(1, 0, 0); chk_rd("c3", 0, 0); chk_out("c3", 32'h4);
    chk("c3.auipc", 32'(op_opcode), 32'h17);
    go(1, 0, 0); chk_rd("c4", 0, 0); chk_out("c4", 32'h4);
    go(1, 0, 0); chk_rd("c5", 0, 0); chk_out("c5", 32'h4);
    go(0, 0, 0); chk_rd("c6", 1, 32'hC); chk_out("c6", 32'h4);
    go(0, 0, 0); chk_rd("c7", 1, 32'h10); chk_out("c7", 32'h8);
    // Redirect to 0x100 while the 0x10 read is in flight.
    go(0, 1, 32'h100); chk_rd("c8", 0, 0); chk_out("c8", 32'hC);
    go(0, 0, 0); chk_rd("c9", 1, 32'h100); chk("c9.valid", 32'(op_instr_valid), 0);
    go(0, 0, 0); chk_rd("c10", 1, 32'h104); chk("c10.valid", 32'(op_instr_valid), 0);
    go(0, 0, 0); chk_rd("c11", 1, 32'h108); chk_out("c11", 32'h100);
    // Fill the skid, then redirect and stall together to 0x40.
    go(1, 0, 0); chk_rd("c12", 0, 0); chk_out("c12", 32'h104);
    go(1, 1, 32'h40); chk_rd("c13", 0, 0); chk_out("c13", 32'h104);
    go(1, 0, 0); chk_rd("c14", 0, 0); chk("c14.valid", 32'(op_instr_valid), 0);
    go(0, 0, 0); chk_rd("c15", 1, 32'h40); chk("c15.valid", 32'(op_instr_valid), 0);
    go(0, 0, 0); chk_rd("c16", 1, 32'h44); chk("c16.valid", 32'(op_instr_valid), 0);
    go(0, 0, 0); chk_out("c17", 32'h40);
    // PC wrap at the top of the address space.
    go(0, 1, 32'hFFFF_FFFC); chk_rd("c18", 0, 0);
    go(0, 0, 0); chk_rd("c19", 1, 32'hFFFF_FFFC);
    go(0, 0, 0); chk_rd("c20", 1, 32'h0); chk("c20.fault", 32'(op_misaligned_fault), 0);
    go(0, 0, 0); chk_out("c21", 32'hFFFF_FFFC);
    go(0, 0, 0); chk_out("c22", 32'h0); chk("c22.fault", 32'(op_misaligned_fault), 0);
    // Misaligned redirect: fault is terminal, even against a later aligned redirect.
    go(0, 1, 32'h102); chk_rd("c23", 0, 0); chk("c23.fault", 32'(op_misaligned_fault), 0);
    go(0, 0, 0); chk("c24.fault", 32'(op_misaligned_fault), 1);
    chk_rd("c24", 0, 0); chk("c24.valid", 32'(op_instr_valid), 0);
    go(0, 1, 32'h200); chk("c25.fault", 32'(op_misaligned_fault), 1);
    for (int i = 0; i < 3; i++) begin
      go(0, 0, 0);
      chk("flt.fault", 32'(op_misaligned_fault), 1);
      chk_rd("flt", 0, 0);
      chk("flt.valid", 32'(op_instr_valid), 0);
    end
    // Asynchronous reset pulse mid-cycle clears everything at once.
    #2 ip_rst_n = 1'b0;
    #1;
    chk("arst.fault", 32'(op_misaligned_fault), 0);
    chk("arst.valid", 32'(op_instr_valid), 0);
    chk("arst.rd_en", 32'(op_imem_rd_en), 0);
    chk("arst.addr", op_imem_addr, 32'h0);
    @(posedge ip_clk_tb);
    #1 ip_rst_n = 1'b1;
    #4 chk("re.idle_rd", 32'(op_imem_rd_en), 0);
    go(0, 0, 0); chk_rd("re0", 1, 32'h0);
    go(0, 0, 0); chk_rd("re1", 1, 32'h4); chk("re1.valid", 32'(op_instr_valid), 0);
    go(0, 0, 0); chk_out("re2", 32'h0);

    // Randomized traffic against a program-order stream model: every consumed instruction
    // must be the next sequential PC since the last redirect, carrying that address's word.
    exp_pc   = 32'h4;
    consumed = 0;
    prev_re  = 1'b0;
    for (int i = 0; i < 400; i++) begin
      st  = ($urandom_range(0, 99) < 30);
      re  = ($urandom_range(0, 99) < 6);
      rpc = $urandom & 32'hFFFF_FFFC;
      go(st, re, rpc);
      if (prev_re) chk("rnd.valid_after_redirect", 32'(op_instr_valid), 0);
      if (st || re) chk("rnd.rd_blocked", 32'(op_imem_rd_en), 0);
      else chk("rnd.rd_free", 32'(op_imem_rd_en), 1);
      if (re) begin
        exp_pc = rpc;
      end else if (op_instr_valid && !st) begin
        chk("rnd.pc", op_pc, exp_pc);
        chk("rnd.instr", op_instr, mem_word(exp_pc));
        exp_pc   = exp_pc + 32'd4;
        consumed = consumed + 1;
      end
      prev_re = re;
    end
    chk("rnd.progress", 32'(consumed >= 100), 32'd1);
    chk("rnd.fault", 32'(op_misaligned_fault), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
